// File: rtl/divide_pkg.sv
// Shared types and constants for the signed fixed-point divider:
// status flags, engine state encoding and saturation bounds.
package divide_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int FLAG_DBZ = 1;
    localparam int FLAG_OVF = 0;

    typedef struct packed {
        logic dbz;
        logic ovf;
    } flags_t;

    // Bit patterns of the largest positive and most negative w-bit values;
    // min_neg also equals the largest negative magnitude 2^(w-1).
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/divide_if.sv
// Upstream FWFT read port and downstream result-queue port of the divider.
interface divide_if #(
    parameter int D_BITS    = 32,
    parameter int OUT_DEPTH = 16
);
    logic signed [D_BITS-1:0]    dividend;
    logic signed [D_BITS-1:0]    divisor;
    logic                        in_empty;
    logic                        in_rd_en;
    logic                        out_empty;
    logic                        out_rd_en;
    logic signed [D_BITS-1:0]    out_dout;
    logic [1:0]                  out_flags;
    logic [$clog2(OUT_DEPTH):0]  out_count;

    modport master (
        output dividend, divisor, in_empty, out_rd_en,
        input  in_rd_en, out_empty, out_dout, out_flags, out_count
    );

    modport slave (
        input  dividend, divisor, in_empty, out_rd_en,
        output in_rd_en, out_empty, out_dout, out_flags, out_count
    );
endinterface

// File: rtl/divide_core.sv
// Iterative restoring divider on operand magnitudes: IDLE latches operands,
// CALC resolves BITS_PER_CYCLE quotient bits per cycle, FIN signs/saturates.
module divide_core
    import divide_pkg::*;
#(
    parameter int Q_BITS         = 10,
    parameter int D_BITS         = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [D_BITS-1:0] dividend,
    input  logic signed [D_BITS-1:0] divisor,
    output logic                     idle,
    output logic                     wr_en,
    output logic signed [D_BITS-1:0] wr_data,
    output flags_t                   wr_flags
);
    localparam int N    = D_BITS + Q_BITS;
    localparam int ITER = N / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [D_BITS-1:0] MAX_POS = D_BITS'(max_pos(D_BITS));
    localparam logic [D_BITS-1:0] MIN_NEG = D_BITS'(min_neg(D_BITS));

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      num_q, num_d, num_t;
    logic [D_BITS:0]   rem_q, rem_d, rem_t;
    logic [D_BITS-1:0] den_q, den_d;
    logic              sn_q, sn_d, sd_q, sd_d;
    logic [D_BITS-1:0] abs_n, abs_d;
    logic [D_BITS+1:0] fin;

    // Returns {flags, result}. mag is the unsigned quotient magnitude, or the
    // latched dividend magnitude when the divisor was zero.
    function automatic logic [D_BITS+1:0] finish_result(
        input logic [N-1:0] mag,
        input logic         den_zero,
        input logic         neg_n,
        input logic         neg_d
    );
        flags_t            fl;
        logic [D_BITS-1:0] res;
        logic              neg;
        fl  = '0;
        res = '0;
        neg = (neg_n ^ neg_d) && (mag != '0);
        if (den_zero) begin
            fl.dbz = 1'b1;
            if (mag != '0)
                res = neg_n ? MIN_NEG : MAX_POS;
        end else if (!neg && (mag > {{Q_BITS{1'b0}}, MAX_POS})) begin
            fl.ovf = 1'b1;
            res    = MAX_POS;
        end else if (neg && (mag > {{Q_BITS{1'b0}}, MIN_NEG})) begin
            fl.ovf = 1'b1;
            res    = MIN_NEG;
        end else begin
            res = neg ? -mag[D_BITS-1:0] : mag[D_BITS-1:0];
        end
        return {fl, res};
    endfunction

    // Unsigned view makes -2^(D_BITS-1) map onto its exact magnitude.
    assign abs_n = dividend[D_BITS-1] ? $unsigned(-dividend) : $unsigned(dividend);
    assign abs_d = divisor[D_BITS-1]  ? $unsigned(-divisor)  : $unsigned(divisor);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        rem_d   = rem_q;
        den_d   = den_q;
        sn_d    = sn_q;
        sd_d    = sd_q;
        num_t   = num_q;
        rem_t   = rem_q;
        wr_en   = 1'b0;
        fin     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = {abs_n, {Q_BITS{1'b0}}};
                    den_d   = abs_d;
                    rem_d   = '0;
                    sn_d    = dividend[D_BITS-1];
                    sd_d    = divisor[D_BITS-1];
                    cnt_d   = '0;
                    state_d = (divisor == '0) ? FIN : CALC;
                end
            end
            CALC: begin
                // num holds untouched dividend bits above, quotient bits below.
                for (int b = 0; b < BITS_PER_CYCLE; b++) begin
                    rem_t = {rem_t[D_BITS-1:0], num_t[N-1]};
                    num_t = {num_t[N-2:0], 1'b0};
                    if (rem_t >= {1'b0, den_q}) begin
                        rem_t    = rem_t - {1'b0, den_q};
                        num_t[0] = 1'b1;
                    end
                end
                num_d = num_t;
                rem_d = rem_t;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1))
                    state_d = FIN;
            end
            FIN: begin
                wr_en   = 1'b1;
                fin     = finish_result(num_q, den_q == '0, sn_q, sd_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        num_q <= num_d;
        rem_q <= rem_d;
        den_q <= den_d;
        sn_q  <= sn_d;
        sd_q  <= sd_d;
    end

    assign idle     = (state_q == IDLE);
    assign wr_data  = fin[D_BITS-1:0];
    assign wr_flags = fin[D_BITS+1:D_BITS];

endmodule

// File: rtl/divide_pipe_top.sv
// Signed fixed-point divider: upstream pop gating, one divide_core engine,
// and a circular FWFT result queue of OUT_DEPTH entries.
module divide_pipe_top
    import divide_pkg::*;
#(
    parameter int Q_BITS         = 10,
    parameter int D_BITS         = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int OUT_DEPTH      = 16
) (
    input logic  clock,
    input logic  reset,
    divide_if.slave io
);
    localparam int AW   = $clog2(OUT_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int EW   = D_BITS + 2;

    logic                     core_idle;
    logic                     start;
    logic                     wr_en;
    logic                     pop;
    logic                     empty;
    logic signed [D_BITS-1:0] wr_data;
    flags_t                   wr_flags;
    logic [EW-1:0]            mem_q [OUT_DEPTH];
    logic [EW-1:0]            head;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]          count_q, count_d;

    // Only one division is ever in flight, so gating the start on free space
    // guarantees the FIN write never meets a full queue.
    assign start = core_idle && !reset && !io.in_empty && (count_q < CNTW'(OUT_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = io.out_rd_en && !empty;

    divide_core #(
        .Q_BITS         (Q_BITS),
        .D_BITS         (D_BITS),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dividend (io.dividend),
        .divisor  (io.divisor),
        .idle     (core_idle),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_flags (wr_flags)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= {wr_flags, wr_data};
    end

    // Head is masked while empty so stale storage never shows on the outputs.
    assign head         = mem_q[rd_ptr_q];
    assign io.in_rd_en  = start;
    assign io.out_empty = empty;
    assign io.out_count = count_q;
    assign io.out_dout  = empty ? '0 : head[D_BITS-1:0];
    assign io.out_flags = empty ? '0 : head[EW-1:D_BITS];

endmodule

// File: doc/divide_pipe_top.md
Name: divide_pipe_top

Overview:
Next-generation signed fixed-point divider block for the ray-tracer datapath. It reads dividend/divisor pairs from an upstream first-word-fall-through FIFO and computes quotient = (dividend << Q_BITS) / divisor with a configurable radix (quotient bits per cycle). Results are saturated, tagged with status flags, and buffered in an internal output queue of parametrised depth. New over the previous divider: radix parameter, divide-by-zero and overflow saturation with flags, a sized output queue, and start-gating on output space.

Parameters:
Q_BITS, 10, fractional bits of the fixed-point format
D_BITS, 32, operand and quotient width
BITS_PER_CYCLE, 2, quotient bits resolved per iteration; (D_BITS+Q_BITS) % BITS_PER_CYCLE == 0 is required
OUT_DEPTH, 16, output queue entries; power of 2, >= 2
ITER (localparam), (D_BITS+Q_BITS)/BITS_PER_CYCLE, iteration cycles

Ports:
clock  in  1  single clock
reset  in  1  asynchronous, active-high reset
dividend  in  D_BITS  signed, valid whenever in_empty=0 (FWFT)
divisor  in  D_BITS  signed, valid whenever in_empty=0
in_empty  in  1  upstream FIFO empty
in_rd_en  out  1  pop upstream; operands are sampled in the same cycle
out_empty  out  1  output queue empty
out_rd_en  in  1  pop output queue
out_dout  out  D_BITS  signed quotient at queue head (FWFT)
out_flags  out  2  head status {dbz, ovf}
out_count  out  $clog2(OUT_DEPTH)+1  entries held

Behaviour:
- Clock and reset: one clock, named clock. Reset is asynchronous and active-high, named reset.
- Reset values: in_rd_en=0, out_empty=1, out_count=0, out_dout=0, out_flags=0, FSM=IDLE, pointers=0.
- Reset mid-operation: the in-flight division is discarded and all queue contents are lost.
- FSM states and transitions:
  - IDLE: in_rd_en = !in_empty && (out_count < OUT_DEPTH), combinational. When it fires, latch |dividend|<<Q_BITS (D_BITS+Q_BITS bits), |divisor| (D_BITS bits), and both signs.
    - divisor==0 -> FIN.
    - otherwise -> CALC.
  - CALC: restoring division, BITS_PER_CYCLE quotient bits per cycle, MSB first, ITER cycles, then -> FIN.
  - FIN: apply sign (negative iff signs differ and magnitude != 0), saturate, write the queue, -> IDLE.
- Timing:
  - in_rd_en is never asserted outside IDLE.
  - Throughput is one result per ITER+2 cycles.
  - Latency from the in_rd_en cycle to out_empty falling: ITER+2 cycles (default 23). For divisor==0 it is 2 cycles.
- Arithmetic:
  - Truncation toward zero.
  - Overflow: positive magnitude > 2^(D_BITS-1)-1 gives 2^(D_BITS-1)-1; negative magnitude > 2^(D_BITS-1) gives -2^(D_BITS-1). Either case sets ovf.
  - Divide by zero: dbz=1. Result is max positive if dividend>0, min negative if dividend<0, 0 if dividend==0. ovf=0.
  - Dividend of -2^(D_BITS-1) is handled exactly: its magnitude fits unsigned.
- Output queue:
  - Circular buffer of OUT_DEPTH entries, each D_BITS+2 bits. FWFT head is on out_dout/out_flags.
  - out_rd_en while empty is ignored.
  - A write in FIN never meets a full queue, because the start is gated on out_count < OUT_DEPTH and only one division is in flight.
  - A simultaneous FIN write and out_rd_en leaves out_count unchanged.
  - Pointers wrap modulo OUT_DEPTH.
- Upstream contract: in_empty is not re-sampled after the pop.

Decomposition:
- Shared package divide_pkg holds:
  - status flag typedef (dbz, ovf bit positions)
  - FSM state enum
  - saturation constant functions (max_pos(D_BITS), min_neg(D_BITS))
- Sub-module divide_core holds the IDLE/CALC/FIN engine: iterative magnitude divider with sign and saturation, write strobe out.
- The top holds the input gating and the output circular buffer.

Test Plan:
- Q=10, D=32: 3072/1536 (3.0/1.5) -> out_dout=2048, flags=00, out_empty falls exactly 23 cycles after the in_rd_en cycle.
- -1024/4096 -> -256. 1024/3072 -> 341. -1024/3072 -> -341 (truncation toward zero).
- 7/0 -> 0x7FFFFFFF, dbz=1, latency 2. -5/0 -> 0x80000000, dbz=1. 0/0 -> 0, dbz=1.
- 0x7FFFFFFF/1 -> 0x7FFFFFFF, ovf=1. 0x80000000/1 -> 0x80000000, ovf=1. 0x80000000/0xFFFFFFFF -> 0x7FFFFFFF, ovf=1.
- Hold out_rd_en=0 and feed 20 pairs -> exactly 16 pops, out_count=16, in_rd_en stays 0. Then one out_rd_en -> the 17th division starts next cycle; order and values are preserved across pointer wrap.
- Assert reset during CALC -> outputs return to reset values immediately. Post-reset operation is clean, with no stale entry.
